// File: rtl/truth_table_sequencer.sv
// ============================================================================
// Module  : truth_table_sequencer
// Brief   : Sweeps every input vector of a combinational DUT and captures its
//           truth table. Optional macro TT_FIRST_FAIL_EN adds first-fail report.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sequencer #(
   parameter int                     N_IN     = 4,
   parameter int                     SETTLE   = 2,
   parameter logic [(1<<N_IN)-1:0]   EXPECTED = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  f,
   output logic [N_IN-1:0]       vec,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_IN:0]         mismatch_cnt,
   output logic [(1<<N_IN)-1:0]  tt_out
`ifdef TT_FIRST_FAIL_EN
   ,
   output logic                  first_fail_vld,
   output logic [N_IN-1:0]       first_fail_idx
`endif
);

   localparam int C_CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [C_CW-1:0]   r_cnt;
   logic              w_clear;
   logic              w_sample;
   logic              w_last;
   logic              w_mis;

   assign w_last = (r_vec_is_last());
   assign w_mis  = (f != EXPECTED[vec]);

   function automatic logic r_vec_is_last();
      return (vec == N_IN'((1 << N_IN) - 1));
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_sample    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_WAIT;
               w_clear     = 1'b1;
            end
         end
         S_WAIT: begin
            if (r_cnt == C_CW'(SETTLE - 1)) begin
               w_state_nxt = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            w_sample    = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_WAIT;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // abort overrides everything, including a simultaneous start
      if (abort) begin
         w_state_nxt = S_IDLE;
         w_clear     = 1'b0;
         w_sample    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || abort) begin
         vec          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         mismatch_cnt <= '0;
         tt_out       <= '0;
         r_cnt        <= '0;
      end else if (w_clear) begin
         vec          <= '0;
         busy         <= 1'b1;
         done         <= 1'b0;
         pass         <= 1'b0;
         mismatch_cnt <= '0;
         tt_out       <= '0;
         r_cnt        <= '0;
      end else if (w_sample) begin
         tt_out[vec] <= f;
         if (w_mis) begin
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
         end
         r_cnt <= '0;
         if (w_last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (mismatch_cnt == '0) && !w_mis;
         end else begin
            vec <= vec + N_IN'(1);
         end
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt + C_CW'(1);
      end
   end

`ifdef TT_FIRST_FAIL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst || abort || w_clear) begin
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
      end else if (w_sample && w_mis && !first_fail_vld) begin
         first_fail_vld <= 1'b1;
         first_fail_idx <= vec;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer: random and directed truth
// tables checked against a per-vector reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_truth_table_sequencer;

   localparam int N    = 4;
   localparam int S    = 2;
   localparam int W    = 1 << N;
   localparam int PER  = S + 1;
   localparam int LAST = 1 + W * PER;
   localparam logic [W-1:0] EXP = 16'hA5C3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  tb_table = '0;
   logic          f;
   logic [N-1:0]  vec;
   logic          busy, done, pass;
   logic [N:0]    mismatch_cnt;
   logic [W-1:0]  tt_out;
`ifdef TT_FIRST_FAIL_EN
   logic          first_fail_vld;
   logic [N-1:0]  first_fail_idx;
`endif

   int total = 0;
   int bad   = 0;

   assign f = tb_table[vec];

   always #5 clk = ~clk;

   truth_table_sequencer #(.N_IN(N), .SETTLE(S), .EXPECTED(EXP)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .f(f),
      .vec(vec), .busy(busy), .done(done), .pass(pass),
      .mismatch_cnt(mismatch_cnt), .tt_out(tt_out)
`ifdef TT_FIRST_FAIL_EN
      , .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
`endif
   );

   function automatic int count_diff(input logic [W-1:0] t);
      int c = 0;
      for (int i = 0; i < W; i++) if (t[i] !== EXP[i]) c++;
      return c;
   endfunction

   function automatic int first_diff(input logic [W-1:0] t);
      for (int i = 0; i < W; i++) if (t[i] !== EXP[i]) return i;
      return 0;
   endfunction

   task automatic check_idle_zero(input string name);
      total++;
      if (vec !== '0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
          mismatch_cnt !== '0 || tt_out !== '0) begin
         bad++;
         $display("FAIL %s: vec=%0d busy=%b done=%b pass=%b mc=%0d tt=%h, required all zero",
                  name, vec, busy, done, pass, mismatch_cnt, tt_out);
      end
`ifdef TT_FIRST_FAIL_EN
      total++;
      if (first_fail_vld !== 1'b0 || first_fail_idx !== '0) begin
         bad++;
         $display("FAIL %s_ff: vld=%b idx=%0d, required 0/0", name, first_fail_vld, first_fail_idx);
      end
`endif
   endtask

   // Full sweep; optionally pulses start (sampled) at edge 'poke' mid-sweep.
   task automatic run_sweep(input logic [W-1:0] tbl, input int poke, input string name);
      int            exp_mc;
      logic [N-1:0]  ev;
      tb_table = tbl;
      exp_mc   = count_diff(tbl);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int e = 1; e <= LAST; e++) begin
         if (e > 1) @(negedge clk);
         if (e == 1) begin
            total++;
            if (tt_out !== '0 || mismatch_cnt !== '0 || done !== 1'b0) begin
               bad++;
               $display("FAIL %s_clear: tt=%h mc=%0d done=%b, required 0/0/0",
                        name, tt_out, mismatch_cnt, done);
            end
         end
         if (e < LAST) begin
            ev = N'((e - 1) / PER);
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || vec !== ev) begin
               bad++;
               $display("FAIL %s_progress edge %0d: busy=%b done=%b vec=%0d, required 1/0/%0d",
                        name, e, busy, done, vec, ev);
            end
         end
         start = (e == poke - 1);
      end
      start = 1'b0;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || vec !== N'(W - 1)) begin
         bad++;
         $display("FAIL %s_done edge %0d: done=%b busy=%b vec=%0d, required 1/0/%0d",
                  name, LAST, done, busy, vec, W - 1);
      end
      total++;
      if (tt_out !== tbl || mismatch_cnt !== (N+1)'(exp_mc) || pass !== (exp_mc == 0)) begin
         bad++;
         $display("FAIL %s_result: tt=%h mc=%0d pass=%b, required %h/%0d/%b",
                  name, tt_out, mismatch_cnt, pass, tbl, exp_mc, exp_mc == 0);
      end
`ifdef TT_FIRST_FAIL_EN
      total++;
      if (first_fail_vld !== (exp_mc != 0) ||
          (exp_mc != 0 && first_fail_idx !== N'(first_diff(tbl)))) begin
         bad++;
         $display("FAIL %s_first_fail: vld=%b idx=%0d, required %b/%0d",
                  name, first_fail_vld, first_fail_idx, exp_mc != 0, first_diff(tbl));
      end
`endif
      repeat (3) @(negedge clk);
      total++;
      if (done !== 1'b1 || tt_out !== tbl || vec !== N'(W - 1)) begin
         bad++;
         $display("FAIL %s_hold: done=%b tt=%h vec=%0d, required 1/%h/%0d",
                  name, done, tt_out, vec, tbl, W - 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_idle_zero("idle_no_start");
   endtask

   task automatic test_match();
      run_sweep(EXP, 0, "match");
   endtask

   task automatic test_two_flips();
      run_sweep(EXP ^ W'((1 << 5) | (1 << 12)), 0, "two_flips");
   endtask

   task automatic test_all_wrong();
      run_sweep(~EXP, 0, "all_wrong");
   endtask

   task automatic test_random();
      repeat (4) run_sweep(W'($urandom), 0, "random");
   endtask

   task automatic test_back_to_back();
      run_sweep(EXP ^ W'(1 << 9), 20, "busy_start");
      run_sweep(W'($urandom), 0, "restart_from_done");
   endtask

   task automatic test_abort();
      tb_table = EXP;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (28) @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      check_idle_zero("abort");
      repeat (6) @(negedge clk);
      check_idle_zero("abort_no_restart");
   endtask

   task automatic test_reset_mid();
      tb_table = EXP;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (1 + 7 * PER - 1) @(negedge clk);
      total++;
      if (vec !== N'(7) || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre_reset: vec=%0d busy=%b, required 7/1", vec, busy);
      end
      #2 rst = 1'b1;
      #1 check_idle_zero("async_reset");
      @(negedge clk); rst = 1'b0;
      repeat (5) @(negedge clk);
      check_idle_zero("post_reset_idle");
      run_sweep(EXP, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_match();
      test_two_flips();
      test_all_wrong();
      test_random();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
